// File: rtl/spi_reg_bank.sv
// spi_reg_bank: system-clock side of the SPI slave byte interface.
// Synchronises the slave's write/read strobes and commits written bytes into
// NREGS 8-bit registers. Address/data are pipelined alongside the write strobe
// synchroniser so they line up at commit time. Readback is a free-running
// lookup of the slave address, registered onto spi_idata.
// Optional feature: define SPI_REG_STATUS_EN to make address 8'hFF return
// {ovf, wcnt[6:0]}; otherwise 8'hFF reads 8'h00.
module spi_reg_bank #(
  parameter int         NREGS   = 8,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         spi_addr,
  input  logic [7:0]         spi_data,
  input  logic               spi_wrstb,
  input  logic               spi_rdstb,
  output logic [7:0]         spi_idata,
  output logic [NREGS*8-1:0] regs,
  output logic               wr_pulse,
  output logic [7:0]         wr_addr
);

  localparam logic [8:0] NREGS_W = 9'(NREGS);

  logic       ws1, ws2, ws3;
  logic       rs1, rs2, rs3;
  logic [7:0] a1, a2, d1, d2, ra1;
  logic [7:0] reg_q [NREGS];
  logic       commit, commit_ok, rd_evt;
  logic [7:0] status, lookup;

  assign commit    = ws2 & ~ws3;
  assign commit_ok = commit & ({1'b0, a2} < NREGS_W);
  assign rd_evt    = rs2 & ~rs3;

  // Strobe synchronisers and the address/data pipeline. Strobe stages reset
  // high so a strobe held across reset release is not seen as a rising edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ws1 <= 1'b1; ws2 <= 1'b1; ws3 <= 1'b1;
      rs1 <= 1'b1; rs2 <= 1'b1; rs3 <= 1'b1;
      a1  <= 8'h00; a2 <= 8'h00;
      d1  <= 8'h00; d2 <= 8'h00;
      ra1 <= 8'h00;
    end else begin
      ws1 <= spi_wrstb; ws2 <= ws1; ws3 <= ws2;
      rs1 <= spi_rdstb; rs2 <= rs1; rs3 <= rs2;
      a1  <= spi_addr;  a2  <= a1;
      d1  <= spi_data;  d2  <= d1;
      ra1 <= spi_addr;
    end
  end

  // Register bank: commit d2 into register a2 when the address is in range.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) reg_q[k] <= RST_VAL;
    end else begin
      for (int k = 0; k < NREGS; k++) begin
        if (commit_ok && (a2 == k[7:0])) reg_q[k] <= d2;
      end
    end
  end

  // Write notification: one-clk pulse and sticky address of the last commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_pulse <= 1'b0;
      wr_addr  <= 8'h00;
    end else begin
      wr_pulse <= commit_ok;
      if (commit_ok) wr_addr <= a2;
    end
  end

`ifdef SPI_REG_STATUS_EN
  logic [6:0] wcnt;
  logic       ovf;
  logic       status_clr;

  assign status_clr = rd_evt && (ra1 == 8'hFF);
  assign status     = {ovf, wcnt};

  // Write counter with sticky wrap flag; a status read clears both, and a
  // commit landing on the clear cycle is counted after the clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt <= 7'd0;
      ovf  <= 1'b0;
    end else if (status_clr && commit_ok) begin
      wcnt <= 7'd1;
      ovf  <= 1'b0;
    end else if (status_clr) begin
      wcnt <= 7'd0;
      ovf  <= 1'b0;
    end else if (commit_ok) begin
      wcnt <= wcnt + 7'd1;
      if (wcnt == 7'h7F) ovf <= 1'b1;
    end
  end
`else
  logic unused_rd_evt;
  assign unused_rd_evt = rd_evt;
  assign status        = 8'h00;
`endif

  // Readback lookup of the sampled address; reflects pre-commit contents.
  always_comb begin
    lookup = 8'h00;
    for (int k = 0; k < NREGS; k++) begin
      if (ra1 == k[7:0]) lookup = reg_q[k];
    end
    if (ra1 == 8'hFF) lookup = status;
  end

  // Registered readback byte presented to the slave.
  always_ff @(posedge clk) begin
    if (!rst_n) spi_idata <= 8'h00;
    else        spi_idata <= lookup;
  end

  // Flatten the bank: register k occupies bits [8k+7:8k].
  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs[8*g +: 8] = reg_q[g];
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank with a write/read scoreboard.
module tb_spi_reg_bank;

  localparam int NR = 8;

  logic            clk;
  logic            rst_n;
  logic [7:0]      spi_addr, spi_data;
  logic            spi_wrstb, spi_rdstb;
  logic [7:0]      spi_idata;
  logic [NR*8-1:0] regs;
  logic            wr_pulse;
  logic [7:0]      wr_addr;

  spi_reg_bank #(.NREGS(NR), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_addr(spi_addr), .spi_data(spi_data),
    .spi_wrstb(spi_wrstb), .spi_rdstb(spi_rdstb),
    .spi_idata(spi_idata), .regs(regs),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] rq[$];

  logic [7:0] model_regs [NR];
  logic [7:0] exp_wr_addr;
  logic [6:0] wcnt_m;
  logic       ovf_m;
  int         pulse_cnt = 0;
  int         n_assert  = 0;
  int         n_fail    = 0;

  always @(negedge clk) if (wr_pulse === 1'b1) pulse_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR*8-1:0] model_vec();
    logic [NR*8-1:0] v;
    for (int k = 0; k < NR; k++) v[8*k +: 8] = model_regs[k];
    return v;
  endfunction

  function automatic logic [7:0] model_lookup(input logic [7:0] a);
    if (a < NR) return model_regs[a[2:0]];
`ifdef SPI_REG_STATUS_EN
    if (a == 8'hFF) return {ovf_m, wcnt_m};
`endif
    return 8'h00;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NR; k++) model_regs[k] = 8'h00;
    exp_wr_addr = 8'h00;
    wcnt_m      = 7'd0;
    ovf_m       = 1'b0;
  endtask

  task automatic spi_write(input logic [7:0] a, input logic [7:0] d);
    bit  hit;
    int  n;
    int  p0;
    wr_t e;
    hit = (a < NR);
    p0  = pulse_cnt;
    spi_addr = a;
    spi_data = d;
    repeat (4) @(negedge clk);
    if (hit) begin
      wq.push_back('{addr: a, data: d});
      model_regs[a[2:0]] = d;
      exp_wr_addr = a;
      if (wcnt_m == 7'h7F) ovf_m = 1'b1;
      wcnt_m = wcnt_m + 7'd1;
    end
    spi_wrstb = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (wr_pulse !== 1'b1 && n < 8);
    if (hit) begin
      check($sformatf("wr_latency a=%0h", a), 64'(n), 64'd3);
      e = wq.pop_front();
      check($sformatf("wr_addr a=%0h", a), 64'(wr_addr), 64'(e.addr));
      check($sformatf("reg_byte a=%0h", a), 64'(regs[8*e.addr[2:0] +: 8]), 64'(e.data));
      check($sformatf("regs a=%0h", a), 64'(regs), 64'(model_vec()));
      @(negedge clk);
      check($sformatf("wr_pulse_width a=%0h", a), 64'(wr_pulse), 64'd0);
    end else begin
      check($sformatf("oor_no_pulse a=%0h", a), 64'(wr_pulse), 64'd0);
      check($sformatf("oor_wr_addr a=%0h", a), 64'(wr_addr), 64'(exp_wr_addr));
      check($sformatf("oor_regs a=%0h", a), 64'(regs), 64'(model_vec()));
    end
    spi_wrstb = 1'b0;
    repeat (6) @(negedge clk);
    check($sformatf("pulse_count a=%0h", a), 64'(pulse_cnt - p0), hit ? 64'd1 : 64'd0);
  endtask

  task automatic spi_read(input logic [7:0] a);
    spi_addr = a;
    repeat (3) @(negedge clk);
    rq.push_back(model_lookup(a));
    spi_rdstb = 1'b1;
    @(negedge clk);
    check($sformatf("readback a=%0h", a), 64'(spi_idata), 64'(rq.pop_front()));
`ifdef SPI_REG_STATUS_EN
    if (a == 8'hFF) begin
      wcnt_m = 7'd0;
      ovf_m  = 1'b0;
    end
`endif
    repeat (5) @(negedge clk);
    spi_rdstb = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int p0;
    model_reset();
    rst_n     = 1'b0;
    spi_wrstb = 1'b1;
    spi_rdstb = 1'b1;
    spi_addr  = 8'h03;
    spi_data  = 8'h77;
    repeat (2) @(negedge clk);
    check("reset_regs", 64'(regs), 64'd0);
    check("reset_idata", 64'(spi_idata), 64'd0);
    check("reset_wr_pulse", 64'(wr_pulse), 64'd0);
    check("reset_wr_addr", 64'(wr_addr), 64'd0);

    // Release reset with both strobes still high: no commit expected.
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("release_no_pulse", 64'(pulse_cnt), 64'd0);
    check("release_regs", 64'(regs), 64'd0);
    spi_wrstb = 1'b0;
    spi_rdstb = 1'b0;
    repeat (4) @(negedge clk);

    spi_write(8'h03, 8'hA5);
    check("reg3_is_a5", 64'(regs[31:24]), 64'hA5);
    spi_write(8'h08, 8'h5A);
    spi_write(8'hFF, 8'h11);
    check("wr_addr_held", 64'(wr_addr), 64'h03);

    spi_write(8'h02, 8'h3C);
    spi_write(8'h03, 8'hC3);
    spi_write(8'h04, 8'h96);
    spi_read(8'h02);
    spi_read(8'h03);
    spi_read(8'h04);
    spi_read(8'h10);
`ifndef SPI_REG_STATUS_EN
    spi_read(8'hFF);
`endif

    // Reset asserted one clk after ws2 rises, before the commit edge.
    p0 = pulse_cnt;
    spi_addr = 8'h05;
    spi_data = 8'hEE;
    repeat (4) @(negedge clk);
    spi_wrstb = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_pulse", 64'(pulse_cnt - p0), 64'd0);
    check("midrst_regs", 64'(regs), 64'(model_vec()));
    check("midrst_wr_addr", 64'(wr_addr), 64'd0);
    spi_wrstb = 1'b0;
    repeat (4) @(negedge clk);
    spi_read(8'h05);

`ifdef SPI_REG_STATUS_EN
    for (int k = 0; k < 130; k++) spi_write(8'(k % NR), 8'(k));
    check("status_model_82", 64'({ovf_m, wcnt_m}), 64'h82);
    spi_read(8'hFF);
    spi_read(8'hFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
